m2s_pipe: RTL and testbench
===========================

Name: m2s_pipe

Overview:
Forward-path (master-to-slave) register slice chain for a valid/ready stream. It registers `pipe_out_valid` and `pipe_out_data` through NUM_STAGES bubble-collapsing stages, so the forward path is timing-isolated. The ready path stays combinational. Inserted between producer and consumer wherever valid/data timing is critical. It is the forward-direction counterpart of s2m_pipe, which registers the backward (ready) path; the two are cascaded for full isolation.

Parameters:
- DATA_WIDTH, 256, payload width in bits.
- NUM_STAGES, 2, number of register stages; legal range 1..8; elaboration error outside the range.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pipe_in_valid  input  1  upstream beat valid.
- pipe_in_data  input  DATA_WIDTH  upstream payload.
- pipe_in_ready  output  1  block accepts a beat this cycle.
- pipe_out_valid  output  1  registered; downstream beat valid.
- pipe_out_data  output  DATA_WIDTH  registered payload.
- pipe_out_ready  input  1  downstream accepts a beat.

Behaviour:
- Stage k (0 = input side, NUM_STAGES-1 = output side) holds `v[k]` and `d[k]`.
- `rdy_next[k]` is `pipe_out_ready` for the last stage, otherwise `stage_rdy[k+1]`.
- `stage_rdy[k] = !v[k] || rdy_next[k]`. This is bubble-collapsing: an empty stage always accepts, even when downstream is stalled.
- Stage input valid: `pipe_in_valid` for stage 0, otherwise `v[k-1]`.
- Update per stage:
  - `v[k] <= in_valid[k] || (v[k] && !rdy_next[k])`.
  - `d[k]` loads `in_data[k]` only when `in_valid[k] && stage_rdy[k]`; otherwise it holds.
- `pipe_in_ready = stage_rdy[0] && !reset`.
- `pipe_out_valid = v[NUM_STAGES-1]`; `pipe_out_data = d[NUM_STAGES-1]`. No combinational path from inputs to these outputs.
- Latency: an accepted beat appears at the output exactly NUM_STAGES cycles later when there is no stall. Throughput is 1 beat/cycle sustained.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Capacity is NUM_STAGES beats. When full (all v=1) and `pipe_out_ready=0`:
  - `pipe_in_ready=0`;
  - all registers hold.
- Full and `pipe_out_ready=1` in the same cycle:
  - `pipe_in_ready=1`;
  - output pops and input pushes simultaneously;
  - occupancy is unchanged.
- Output stability: while `pipe_out_valid=1 && pipe_out_ready=0`, `pipe_out_valid` and `pipe_out_data` hold stable.
- Upstream may drop `pipe_in_valid` without a handshake; only accepted beats enter the block.
- Reset (asynchronous assert, synchronous-safe deassert):
  - all `v[k]=0` and `d[k]=0`;
  - `pipe_out_valid=0`, `pipe_out_data=0`, `pipe_in_ready=0`;
  - in-flight beats are discarded.
  - The first cycle after deassert has `pipe_in_ready=1`.
- The ready path depth is NUM_STAGES AND/OR levels and is intentionally unregistered.

Optional Feature:
- Macro: M2S_PIPE_STATS_EN.
- When defined, two extra outputs are added:
  - `occupancy`, width $clog2(NUM_STAGES+1): registered count of valid stages.
  - `beat_count`, 32 bits: counts output handshakes (`pipe_out_valid && pipe_out_ready`), saturates at 0xFFFFFFFF.
  - Both reset to 0.
  - `occupancy` increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- When undefined, these ports and their logic do not exist; the datapath is identical either way.

Decomposition:
- Shared package holds:
  - `M2S_PIPE_MAX_STAGES = 8`;
  - a function computing the occupancy width;
  - no typedefs beyond a DATA_WIDTH-parameterised payload type used by the bench.
- One sub-module, `m2s_pipe_stage`: a single valid/data register with bubble-collapse ready. The top level generates NUM_STAGES instances in a chain plus the optional stats logic.

Test Plan:
- Reset, NUM_STAGES=2, send 0xA1 with `pipe_out_ready=1` -> `pipe_in_ready=0` during reset; 0xA1 appears on `pipe_out_data` with `pipe_out_valid=1` exactly 2 cycles after the accept.
- Stream 100 incrementing beats, ready always 1 -> one beat per cycle out, in order, no gaps after the initial 2-cycle fill.
- Send 3 beats with `pipe_out_ready=0` (NUM_STAGES=2) -> first 2 accepted; third sees `pipe_in_ready=0`; output holds beat 0 stable; raising ready drains 0, 1, 2 in order.
- Full pipe, assert `pipe_out_ready=1` and `pipe_in_valid=1` in the same cycle -> simultaneous pop and push; with M2S_PIPE_STATS_EN, `occupancy` stays 2 and `beat_count` increments by 1.
- Assert reset mid-stream with 2 beats in flight -> `pipe_out_valid` drops to 0 asynchronously; after release no stale beat emerges.
- Random valid/ready (50% each), NUM_STAGES=1 and 8, 10k beats -> scoreboard matches and output stability is never violated while stalled.

Source files
------------

// File: rtl/m2s_pipe_pkg.sv
// m2s_pipe shared package: stage limit, payload type, stats width helper.
// Imported by every file of the m2s_pipe slice.
package m2s_pipe_pkg;

  localparam int M2S_PIPE_MAX_STAGES = 8;
  localparam int M2S_PIPE_DATA_WIDTH = 256;

  typedef logic [M2S_PIPE_DATA_WIDTH-1:0] m2s_payload_t;

  function automatic int m2s_occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/m2s_pipe_stage.sv
// m2s_pipe_stage: one registered valid/data slot.
// An empty slot always accepts, so bubbles collapse.
module m2s_pipe_stage
  import m2s_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid || (out_valid && !out_ready);
      if (in_valid && in_ready) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/m2s_pipe.sv
// m2s_pipe: NUM_STAGES forward register slices, combinational ready.
// Define M2S_PIPE_STATS_EN to add occupancy / beat_count outputs.
module m2s_pipe
  import m2s_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_in_valid,
  input  logic [DATA_WIDTH-1:0] pipe_in_data,
  output logic                  pipe_in_ready,
  output logic                  pipe_out_valid,
  output logic [DATA_WIDTH-1:0] pipe_out_data,
  input  logic                  pipe_out_ready
`ifdef M2S_PIPE_STATS_EN
  ,
  output logic [m2s_occ_width(NUM_STAGES)-1:0] occupancy,
  output logic [31:0]           beat_count
`endif
);

  if (NUM_STAGES < 1 ||
      NUM_STAGES > M2S_PIPE_MAX_STAGES) begin : g_bad
    $error("m2s_pipe: NUM_STAGES must be 1..8");
  end

  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] in_v;
  logic [DATA_WIDTH-1:0] d    [NUM_STAGES];
  logic [DATA_WIDTH-1:0] in_d [NUM_STAGES];

  // Ready nets live per stage so the backward chain is not one vector.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic rdy;
    logic rdy_nx;

    if (k == 0) begin : g_head
      assign in_v[k] = pipe_in_valid;
      assign in_d[k] = pipe_in_data;
    end else begin : g_body
      assign in_v[k] = v[k-1];
      assign in_d[k] = d[k-1];
    end

    if (k == NUM_STAGES - 1) begin : g_tail
      assign rdy_nx = pipe_out_ready;
    end else begin : g_link
      assign rdy_nx = g_stage[k+1].rdy;
    end

    m2s_pipe_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_v[k]),
      .in_data   (in_d[k]),
      .in_ready  (rdy),
      .out_valid (v[k]),
      .out_data  (d[k]),
      .out_ready (rdy_nx)
    );
  end

  assign pipe_in_ready  = g_stage[0].rdy && !reset;
  assign pipe_out_valid = v[NUM_STAGES-1];
  assign pipe_out_data  = d[NUM_STAGES-1];

`ifdef M2S_PIPE_STATS_EN
  localparam int OW = m2s_occ_width(NUM_STAGES);

  logic push;
  logic pop;

  assign push = pipe_in_valid && pipe_in_ready;
  assign pop  = pipe_out_valid && pipe_out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy  <= '0;
      beat_count <= '0;
    end else begin
      if (push && !pop) begin
        occupancy <= occupancy + OW'(1);
      end else if (pop && !push) begin
        occupancy <= occupancy - OW'(1);
      end
      if (pop && beat_count != 32'hFFFF_FFFF) begin
        beat_count <= beat_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_m2s_pipe.sv
// tb_m2s_pipe: three lanes (2, 1 and 8 stages) checked by a FIFO model.
// Directed tests run on the 2-stage lane, random traffic on all lanes.
module tb_m2s_pipe;
  import m2s_pipe_pkg::*;

  localparam int DW = M2S_PIPE_DATA_WIDTH;
  localparam int NL = 3;

  function automatic int ns_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         iv  [NL];
  logic         ir  [NL];
  logic         ov  [NL];
  logic         orr [NL];
  m2s_payload_t id  [NL];
  m2s_payload_t od  [NL];
`ifdef M2S_PIPE_STATS_EN
  logic [3:0]   occ [NL];
  logic [31:0]  bc  [NL];
`endif

  for (genvar g = 0; g < NL; g++) begin : lane
`ifdef M2S_PIPE_STATS_EN
    logic [m2s_occ_width(ns_of(g))-1:0] occ_l;
    assign occ[g] = 4'(occ_l);
`endif
    m2s_pipe #(
      .DATA_WIDTH(DW),
      .NUM_STAGES(ns_of(g))
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .pipe_in_valid  (iv[g]),
      .pipe_in_data   (id[g]),
      .pipe_in_ready  (ir[g]),
      .pipe_out_valid (ov[g]),
      .pipe_out_data  (od[g]),
      .pipe_out_ready (orr[g])
`ifdef M2S_PIPE_STATS_EN
      ,
      .occupancy      (occ_l),
      .beat_count     (bc[g])
`endif
    );
  end

  int total = 0;
  int bad = 0;

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic chkd(input string nm, input m2s_payload_t a,
                      input m2s_payload_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  function automatic m2s_payload_t rnd_data();
    m2s_payload_t r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected beats per lane, in acceptance order.
  m2s_payload_t sb [NL][$];
  logic         stalled [NL];
  m2s_payload_t held    [NL];
  int           pops    [NL];

  always @(negedge clk) begin
    for (int g = 0; g < NL; g++) begin
      if (reset) begin
        stalled[g] = 1'b0;
        pops[g] = 0;
      end else begin
        if (stalled[g]) begin
          chk1("hold_valid", ov[g], 1'b1);
          chkd("hold_data", od[g], held[g]);
        end
        chk1("in_ready", ir[g],
             (sb[g].size() < ns_of(g)) || orr[g]);
`ifdef M2S_PIPE_STATS_EN
        chki("occupancy", int'(occ[g]), sb[g].size());
        chki("beat_count", int'(bc[g]), pops[g]);
`endif
        if (ov[g] && orr[g]) begin
          if (sb[g].size() == 0) begin
            chk1("spurious_beat", ov[g], 1'b0);
          end else begin
            chkd("out_data", od[g], sb[g].pop_front());
          end
          pops[g]++;
        end
        stalled[g] = ov[g] && !orr[g];
        held[g] = od[g];
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int g, input m2s_payload_t dat);
    bit ok = 0;
    iv[g] = 1'b1;
    id[g] = dat;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      #1;
      if (ir[g]) begin
        sb[g].push_back(dat);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    iv[g] = 1'b0;
    chk1("send_accept", ok, 1'b1);
  endtask

  task automatic drain(input int g);
    iv[g] = 1'b0;
    orr[g] = 1'b1;
    for (int t = 0; t < 100 && sb[g].size() != 0; t++) begin
      @(posedge clk);
    end
    #1;
    chki("drain_empty", sb[g].size(), 0);
  endtask

  task automatic rand_lane(input int g, input int nbeats);
    int acc = 0;
    for (int c = 0; c < 60000 && acc < nbeats; c++) begin
      iv[g] = 1'($urandom % 2);
      id[g] = rnd_data();
      orr[g] = 1'($urandom % 2);
      @(negedge clk);
      #1;
      if (iv[g] && ir[g]) begin
        sb[g].push_back(id[g]);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    chki("rand_accepted", acc, nbeats);
    drain(g);
  endtask

  m2s_payload_t b0, b1, b2;
  int c0;
`ifdef M2S_PIPE_STATS_EN
  logic [31:0] bc0;
`endif

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NL; g++) begin
      iv[g] = 1'b0;
      id[g] = '0;
      orr[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_in_ready", ir[0], 1'b0);
    chk1("reset_out_valid", ov[0], 1'b0);
    chkd("reset_out_data", od[0], '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("first_ready", ir[0], 1'b1);

    @(posedge clk);
    #1;
    send(0, m2s_payload_t'(8'hA1));
    @(negedge clk);
    #1;
    chk1("lat_not_early", ov[0], 1'b0);
    @(posedge clk);
    #1;
    chk1("lat_valid", ov[0], 1'b1);
    chkd("lat_data", od[0], m2s_payload_t'(8'hA1));

    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(0, m2s_payload_t'(i + 256));
    chki("stream_in_rate", cyc - c0, 100);
    repeat (2) @(negedge clk);
    #1;
    chki("stream_no_gap", sb[0].size(), 0);

    @(posedge clk);
    #1;
    orr[0] = 1'b0;
    b0 = rnd_data();
    b1 = rnd_data();
    b2 = rnd_data();
    send(0, b0);
    send(0, b1);
    iv[0] = 1'b1;
    id[0] = b2;
    @(negedge clk);
    #1;
    chk1("full_in_ready", ir[0], 1'b0);
    chkd("full_out_data", od[0], b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      chk1("stall_valid", ov[0], 1'b1);
      chkd("stall_data", od[0], b0);
    end
    @(posedge clk);
    #1;
    orr[0] = 1'b1;
`ifdef M2S_PIPE_STATS_EN
    bc0 = bc[0];
`endif
    @(negedge clk);
    #1;
    chk1("pushpop_ready", ir[0], 1'b1);
    if (ir[0]) sb[0].push_back(b2);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk1("pushpop_valid", ov[0], 1'b1);
    chkd("pushpop_data", od[0], b1);
`ifdef M2S_PIPE_STATS_EN
    chki("pushpop_occ", int'(occ[0]), 2);
    chki("pushpop_bc", int'(bc[0]), int'(bc0) + 1);
`endif
    drain(0);

    @(posedge clk);
    #1;
    orr[0] = 1'b0;
    send(0, rnd_data());
    send(0, rnd_data());
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_valid", ov[0], 1'b0);
    chk1("async_ready", ir[0], 1'b0);
    chkd("async_data", od[0], '0);
    for (int g = 0; g < NL; g++) sb[g].delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    orr[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk1("no_stale_beat", ov[0], 1'b0);
    end

    @(posedge clk);
    #1;
    fork
      rand_lane(0, 2000);
      rand_lane(1, 10000);
      rand_lane(2, 10000);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
